// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling UART receiver with parity, framing and overrun flags.
// Define UART_RX_MAJORITY_EN to vote each bit 2-of-3 over the samples around its centre.
module uart_rx_os #(
    parameter int clk_freq  = 1_000_000,
    parameter int baud      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV_RAW = clk_freq / (baud * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_DELIVER = 3'd5;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] SAMPLE_SC = 4'd8;
`else
    localparam logic [3:0] SAMPLE_SC = 4'd7;
`endif

    logic [1:0]           sync_reg;
    logic [TW-1:0]        tick_cnt_reg;
    logic [3:0]           sc_reg;
    logic [2:0]           state_reg;
    logic [3:0]           bit_cnt_reg;
    logic [DATA_BITS-1:0] sr_reg;
    logic                 perr_reg;
    logic                 ferr_reg;
    logic [DATA_BITS-1:0] dout_reg;
    logic                 valid_reg;
    logic                 parity_err_reg;
    logic                 frame_err_reg;
    logic                 overrun_reg;

    logic rx_s;
    logic os_tick;
    logic sample;
    logic bit_val;

    assign rx_s    = sync_reg[1];
    assign os_tick = (tick_cnt_reg == TW'(DIV - 1));
    assign sample  = os_tick && (sc_reg == SAMPLE_SC);

`ifdef UART_RX_MAJORITY_EN
    // rx_s held from sc==6 and sc==7; the vote completes with the live sample at sc==8
    logic [1:0] early_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            early_reg <= 2'b11;
        end else if (os_tick && sc_reg == 4'd6) begin
            early_reg[0] <= rx_s;
        end else if (os_tick && sc_reg == 4'd7) begin
            early_reg[1] <= rx_s;
        end
    end

    assign bit_val = (early_reg[0] & early_reg[1]) | (early_reg[0] & rx_s) | (early_reg[1] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    // sc runs on through the whole frame, so every later centre lands 16 ticks after the start centre
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg     <= 2'b11;
            tick_cnt_reg <= '0;
            sc_reg       <= '0;
            state_reg    <= S_IDLE;
            bit_cnt_reg  <= '0;
            sr_reg       <= '0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[0], rx};
            tick_cnt_reg <= os_tick ? '0 : tick_cnt_reg + TW'(1);
            if (os_tick && state_reg != S_IDLE) begin
                sc_reg <= sc_reg + 4'd1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_reg    <= S_START;
                        tick_cnt_reg <= '0;
                        sc_reg       <= '0;
                        bit_cnt_reg  <= '0;
                        perr_reg     <= 1'b0;
                        ferr_reg     <= 1'b0;
                    end
                end
                S_START: begin
                    if (sample) begin
                        state_reg <= bit_val ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (sample) begin
                        sr_reg <= {bit_val, sr_reg[DATA_BITS-1:1]};
                        if (bit_cnt_reg == 4'(DATA_BITS - 1)) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (sample) begin
                        perr_reg  <= (((^sr_reg) ^ bit_val) != (PARITY == 2));
                        state_reg <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (sample) begin
                        ferr_reg <= ferr_reg | ~bit_val;
                        if (bit_cnt_reg == 4'(STOP_BITS - 1)) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= S_DELIVER;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end
                end
                S_DELIVER: state_reg <= S_IDLE;
                default:   state_reg <= S_IDLE;
            endcase
        end
    end

    // A held, unaccepted character is never overwritten: the new one is dropped and flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg       <= '0;
            valid_reg      <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (state_reg == S_DELIVER) begin
                if (!valid_reg || ready) begin
                    dout_reg       <= sr_reg;
                    parity_err_reg <= perr_reg;
                    frame_err_reg  <= ferr_reg;
                    valid_reg      <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (valid_reg && ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign dout       = dout_reg;
    assign valid      = valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != S_IDLE);
endmodule
